// File: rtl/adxl355_pkg.sv
// Shared constants, FSM state type and command helper for the ADXL355 drdy reader.
package adxl355_pkg;

  localparam logic [7:0]  XDATA3    = 8'h08;
  localparam logic [7:0]  FIFO_DATA = 8'h11;
  localparam logic        READ_BIT  = 1'b1;
  localparam int unsigned AXIS_W    = 20;

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StShift,
    StCsHold,
    StDone
  } state_e;

  // ADXL355 SPI command: 7-bit register address followed by the R/W bit in the LSB.
  function automatic logic [7:0] read_cmd(input logic [7:0] addr);
    return {addr[6:0], READ_BIT};
  endfunction

endpackage

// File: rtl/adxl355_drdy_reader_if.sv
// Accelerometer SPI pins; the reader is the master, the sensor (or its model) the slave.
interface adxl355_drdy_reader_if;

  logic csn;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (output csn, sclk, mosi, input miso);
  modport slave  (input csn, sclk, mosi, output miso);

endinterface

// File: rtl/adxl355_spi_shifter.sv
// SPI mode-0 bit engine: SCLK/MOSI generation and MISO capture for one burst.
module adxl355_spi_shifter #(
  parameter int unsigned HalfPeriod = 4,
  parameter int unsigned RxW        = 72
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           load_i,     // preload tx byte; MOSI shows its MSB from the next cycle
  input  logic [7:0]     tx_byte_i,
  input  logic           start_i,    // begin the first SCLK low phase
  input  logic [6:0]     n_bits_i,
  input  logic           miso_i,
  output logic           sclk_o,
  output logic           mosi_o,
  output logic [RxW-1:0] rx_o,       // last RxW bits received, oldest in the MSB
  output logic           done_o      // last SCLK high phase ends at this edge
);

  localparam int unsigned    HcW      = (HalfPeriod > 1) ? $clog2(HalfPeriod) : 1;
  localparam logic [HcW-1:0] HcReload = HcW'(HalfPeriod - 1);

  logic           active_q, active_d;
  logic           high_q, high_d;
  logic [HcW-1:0] hcnt_q, hcnt_d;
  logic [6:0]     bit_q, bit_d;
  logic           sclk_q, sclk_d;
  logic           mosi_q, mosi_d;
  logic [7:0]     tx_q, tx_d;
  logic [RxW-1:0] rx_q, rx_d;

  assign done_o = active_q && high_q && (hcnt_q == '0) && (bit_q == n_bits_i - 7'd1);
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;
  assign rx_o   = rx_q;

  // Phase sequencing: sample MISO as SCLK rises, advance MOSI as SCLK falls.
  always_comb begin
    active_d = active_q;
    high_d   = high_q;
    hcnt_d   = hcnt_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    if (load_i) begin
      mosi_d = tx_byte_i[7];
      tx_d   = {tx_byte_i[6:0], 1'b0};
    end
    if (start_i) begin
      active_d = 1'b1;
      high_d   = 1'b0;
      hcnt_d   = HcReload;
      bit_d    = '0;
    end else if (active_q) begin
      if (hcnt_q != '0) begin
        hcnt_d = hcnt_q - 1'b1;
      end else if (!high_q) begin
        sclk_d = 1'b1;
        high_d = 1'b1;
        hcnt_d = HcReload;
        rx_d   = {rx_q[RxW-2:0], miso_i};
      end else begin
        sclk_d = 1'b0;
        high_d = 1'b0;
        hcnt_d = HcReload;
        mosi_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
        if (done_o) begin
          active_d = 1'b0;
        end else begin
          bit_d = bit_q + 7'd1;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      high_q   <= 1'b0;
      hcnt_q   <= '0;
      bit_q    <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      tx_q     <= '0;
      rx_q     <= '0;
    end else begin
      active_q <= active_d;
      high_q   <= high_d;
      hcnt_q   <= hcnt_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
    end
  end

endmodule

// File: rtl/adxl355_drdy_reader.sv
// On each accepted drdy, burst-reads XDATA3..ZDATA1 and presents three 20-bit axis samples.
module adxl355_drdy_reader
  import adxl355_pkg::*;
#(
  parameter int unsigned clk_out0_hz = 40000000,
  parameter int unsigned spi_div     = 4,
  parameter logic [7:0]  start_addr  = XDATA3,
  parameter int unsigned n_bytes     = 9
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clk_drdy,
  input  logic                  i_enable,
  adxl355_drdy_reader_if.master spi,
  output logic [AXIS_W-1:0]     o_x,
  output logic [AXIS_W-1:0]     o_y,
  output logic [AXIS_W-1:0]     o_z,
  output logic                  o_valid,
  output logic                  o_busy,
  output logic                  o_overrun
);

  localparam int unsigned    RxW      = n_bytes * 8;
  localparam logic [6:0]     NBits    = 7'(RxW + 8);
  localparam int unsigned    HcW      = (spi_div > 1) ? $clog2(spi_div) : 1;
  localparam logic [HcW-1:0] HcReload = HcW'(spi_div - 1);

  state_e            state_q, state_d;
  logic [HcW-1:0]    hcnt_q, hcnt_d;
  logic              overrun_q, overrun_d;
  logic [AXIS_W-1:0] x_q, y_q, z_q;
  logic              accept, start, shift_done, load_axes;
  logic [RxW-1:0]    rx;

  assign accept    = (state_q == StIdle) && i_clk_drdy && i_enable;
  assign load_axes = (state_q == StCsHold) && (hcnt_q == '0);

  adxl355_spi_shifter #(
    .HalfPeriod (spi_div),
    .RxW        (RxW)
  ) u_shifter (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .load_i    (accept),
    .tx_byte_i (read_cmd(start_addr)),
    .start_i   (start),
    .n_bits_i  (NBits),
    .miso_i    (spi.miso),
    .sclk_o    (spi.sclk),
    .mosi_o    (spi.mosi),
    .rx_o      (rx),
    .done_o    (shift_done)
  );

  // Transfer sequencing and CS setup/hold timing.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StCsSetup;
          hcnt_d  = HcReload;
        end
      end
      StCsSetup: begin
        if (hcnt_q == '0) begin
          state_d = StShift;
          start   = 1'b1;
        end else begin
          hcnt_d = hcnt_q - 1'b1;
        end
      end
      StShift: begin
        if (shift_done) begin
          state_d = StCsHold;
          hcnt_d  = HcReload;
        end
      end
      StCsHold: begin
        if (hcnt_q == '0) begin
          state_d = StDone;
        end else begin
          hcnt_d = hcnt_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Overrun is sticky while enabled; disabling the reader clears it.
  always_comb begin
    overrun_d = overrun_q;
    if (!i_enable) begin
      overrun_d = 1'b0;
    end else if (i_clk_drdy && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end
  end

  // FSM, flag and sample registers; the first 8 received bits (command slot) drop off rx.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      hcnt_q    <= '0;
      overrun_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      overrun_q <= overrun_d;
      if (load_axes) begin
        x_q <= rx[RxW-1 -: AXIS_W];
        y_q <= rx[RxW-25 -: AXIS_W];
        z_q <= rx[RxW-49 -: AXIS_W];
      end
    end
  end

  assign spi.csn   = !((state_q == StCsSetup) || (state_q == StShift) || (state_q == StCsHold));
  assign o_busy    = (state_q != StIdle);
  assign o_valid   = (state_q == StDone);
  assign o_overrun = overrun_q;
  assign o_x       = x_q;
  assign o_y       = y_q;
  assign o_z       = z_q;

  // A full burst must finish well inside one 1 kHz drdy period.
  LatencyFits: assert property (@(posedge i_clk) (162 * spi_div + 1) < (clk_out0_hz / 1000));

endmodule

// File: tb/tb_adxl355_drdy_reader.sv
// Directed bench for adxl355_drdy_reader with an ADXL355 SPI slave model.
module tb_adxl355_drdy_reader;
  import adxl355_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, drdy0, en0, drdy1, en1;
  logic [19:0] x0, y0, z0, x1, y1, z1;
  logic        valid0, busy0, ovr0, valid1, busy1, ovr1;

  adxl355_drdy_reader_if spi0();
  adxl355_drdy_reader_if spi1();
  assign spi1.miso = 1'b0;

  adxl355_drdy_reader #(.spi_div(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_drdy(drdy0), .i_enable(en0), .spi(spi0),
    .o_x(x0), .o_y(y0), .o_z(z0), .o_valid(valid0), .o_busy(busy0), .o_overrun(ovr0)
  );

  adxl355_drdy_reader #(.spi_div(1)) dut_fast (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_drdy(drdy1), .i_enable(en1), .spi(spi1),
    .o_x(x1), .o_y(y1), .o_z(z1), .o_valid(valid1), .o_busy(busy1), .o_overrun(ovr1)
  );

  int errors = 0;
  int checks = 0;

  // Sensor model and bus monitor, evaluated away from the active edge.
  bit          rand_miso = 1'b1;
  logic [79:0] stream = '0;
  logic [79:0] shreg = '0;
  logic [79:0] mosi_sr = '0;
  logic        sclk_prev = 1'b0;
  logic        csn_prev = 1'b1;
  int          sclk_rises = 0;
  int          csn_falls = 0;
  int          valid_cnt = 0;
  int          valid1_cnt = 0;

  always @(negedge clk) begin
    if (rand_miso) begin
      spi0.miso = 1'($urandom);
    end else if (csn_prev && !spi0.csn) begin
      shreg     = stream;
      spi0.miso = shreg[79];
      mosi_sr   = '0;
      csn_falls++;
    end else if (!spi0.csn && sclk_prev && !spi0.sclk) begin
      shreg     = {shreg[78:0], 1'b0};
      spi0.miso = shreg[79];
    end
    if (!sclk_prev && spi0.sclk) begin
      sclk_rises++;
      mosi_sr = {mosi_sr[78:0], spi0.mosi};
    end
    if (valid0) valid_cnt++;
    if (valid1) valid1_cnt++;
    sclk_prev = spi0.sclk;
    csn_prev  = spi0.csn;
  end

  task automatic pulse_drdy();
    @(negedge clk);
    drdy0 = 1'b1;
    @(negedge clk);
    drdy0 = 1'b0;
  endtask

  // Counts edges after the accepting edge until o_valid is seen (bounded).
  task automatic wait_valid(input bit fast, output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!(fast ? valid1 : valid0) && lat < 3000);
  endtask

  task automatic wait_rises(input int base, input int n);
    int guard = 0;
    while ((sclk_rises - base) < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic test_reset();
    int r0;
    rst_n = 1'b0; drdy0 = 1'b0; en0 = 1'b1; drdy1 = 1'b0; en1 = 1'b1; rand_miso = 1'b1;
    r0 = sclk_rises;
    repeat (5) @(negedge clk);
    checks++;
    if ({spi0.csn, spi0.sclk, spi0.mosi} !== 3'b100) begin
      errors++; $display("FAIL reset_pins: got %b required 100", {spi0.csn, spi0.sclk, spi0.mosi});
    end
    checks++;
    if ({x0, y0, z0} !== 60'h0) begin
      errors++; $display("FAIL reset_axes: got %h required 0", {x0, y0, z0});
    end
    checks++;
    if ({valid0, busy0, ovr0} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b required 000", {valid0, busy0, ovr0});
    end
    checks++;
    if (sclk_rises - r0 != 0) begin
      errors++; $display("FAIL reset_sclk: got %0d edges required 0", sclk_rises - r0);
    end
    rand_miso = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Full burst with a given byte stream; checks latency, data, SCLK count and command.
  task automatic burst_and_check(input string tag, input logic [71:0] data,
                                 input logic [59:0] exp_xyz);
    int r0, c0, v0, lat;
    stream = {8'h00, data};
    r0 = sclk_rises; c0 = csn_falls; v0 = valid_cnt;
    pulse_drdy();
    checks++;
    if ({spi0.csn, busy0} !== 2'b01) begin
      errors++; $display("FAIL %s_start: got csn,busy=%b required 01", tag, {spi0.csn, busy0});
    end
    wait_valid(1'b0, lat);
    checks++;
    if (lat + 1 != 649) begin
      errors++; $display("FAIL %s_latency: got %0d required 649", tag, lat + 1);
    end
    checks++;
    if ({x0, y0, z0} !== exp_xyz) begin
      errors++; $display("FAIL %s_data: got %h required %h", tag, {x0, y0, z0}, exp_xyz);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (sclk_rises - r0 != 80) begin
      errors++; $display("FAIL %s_sclk: got %0d edges required 80", tag, sclk_rises - r0);
    end
    checks++;
    if (mosi_sr !== {8'h11, 72'h0}) begin
      errors++; $display("FAIL %s_mosi: got %h required %h", tag, mosi_sr, {8'h11, 72'h0});
    end
    checks++;
    if ((valid_cnt - v0 != 1) || (csn_falls - c0 != 1)) begin
      errors++; $display("FAIL %s_counts: got valid=%0d csn=%0d required 1 1", tag,
                         valid_cnt - v0, csn_falls - c0);
    end
    checks++;
    if ({valid0, busy0, spi0.csn} !== 3'b001) begin
      errors++; $display("FAIL %s_idle: got %b required 001", tag, {valid0, busy0, spi0.csn});
    end
  endtask

  task automatic test_single_read();
    burst_and_check("single", 72'h12345FABCDEF80001A, {20'h12345, 20'hABCDE, 20'h80001});
  endtask

  task automatic test_overrun();
    int c0, v0, lat;
    stream = {8'h00, 72'hFFFFF00000107FFFFF};
    c0 = csn_falls; v0 = valid_cnt;
    pulse_drdy();
    repeat (98) @(negedge clk);
    pulse_drdy();
    checks++;
    if (ovr0 !== 1'b1) begin
      errors++; $display("FAIL ovr_set: got %b required 1", ovr0);
    end
    wait_valid(1'b0, lat);
    checks++;
    if (lat != 548) begin
      errors++; $display("FAIL ovr_latency: got %0d required 548", lat);
    end
    checks++;
    if ({x0, y0, z0} !== {20'hFFFFF, 20'h00001, 20'h7FFFF}) begin
      errors++; $display("FAIL ovr_data: got %h required fffff000017ffff", {x0, y0, z0});
    end
    repeat (10) @(negedge clk);
    checks++;
    if ((csn_falls - c0 != 1) || (valid_cnt - v0 != 1)) begin
      errors++; $display("FAIL ovr_single_burst: got csn=%0d valid=%0d required 1 1",
                         csn_falls - c0, valid_cnt - v0);
    end
    checks++;
    if (ovr0 !== 1'b1) begin
      errors++; $display("FAIL ovr_sticky: got %b required 1", ovr0);
    end
  endtask

  task automatic test_enable();
    int c0, r0, v0, lat;
    en0 = 1'b0;
    c0 = csn_falls;
    @(negedge clk);
    pulse_drdy();
    repeat (20) @(negedge clk);
    checks++;
    if ((csn_falls - c0 != 0) || ({spi0.csn, busy0, ovr0} !== 3'b100)) begin
      errors++; $display("FAIL en_ignore: got falls=%0d csn,busy,ovr=%b required 0 100",
                         csn_falls - c0, {spi0.csn, busy0, ovr0});
    end
    en0 = 1'b1;
    stream = {8'h00, 72'h0123456789ABCDEF01};
    r0 = sclk_rises; v0 = valid_cnt;
    pulse_drdy();
    wait_rises(r0, 40);
    checks++;
    if (sclk_rises - r0 != 40) begin
      errors++; $display("FAIL en_bit40: got %0d edges required 40", sclk_rises - r0);
    end
    en0 = 1'b0;
    pulse_drdy();
    wait_valid(1'b0, lat);
    checks++;
    if (valid0 !== 1'b1) begin
      errors++; $display("FAIL en_complete: got valid=%b required 1", valid0);
    end
    checks++;
    if ({x0, y0, z0} !== {20'h01234, 20'h6789A, 20'hCDEF0}) begin
      errors++; $display("FAIL en_data: got %h required 012346789acdef0", {x0, y0, z0});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ((ovr0 !== 1'b0) || (valid_cnt - v0 != 1) || (sclk_rises - r0 != 80)) begin
      errors++; $display("FAIL en_after: got ovr=%b valid=%0d sclk=%0d required 0 1 80",
                         ovr0, valid_cnt - v0, sclk_rises - r0);
    end
    en0 = 1'b1;
  endtask

  task automatic test_mid_reset();
    int r0, v0;
    stream = {8'h00, 72'hFFFFF00000107FFFFF};
    r0 = sclk_rises; v0 = valid_cnt;
    pulse_drdy();
    wait_rises(r0, 40);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({spi0.csn, spi0.sclk, busy0, valid0} !== 4'b1000) begin
      errors++; $display("FAIL mrst_abort: got %b required 1000",
                         {spi0.csn, spi0.sclk, busy0, valid0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (700) @(negedge clk);
    checks++;
    if ((valid_cnt - v0 != 0) || ({x0, y0, z0} !== 60'h0)) begin
      errors++; $display("FAIL mrst_no_valid: got valid=%0d axes=%h required 0 0",
                         valid_cnt - v0, {x0, y0, z0});
    end
    burst_and_check("mrst_next", 72'h12345FABCDEF80001A, {20'h12345, 20'hABCDE, 20'h80001});
  endtask

  task automatic test_fast();
    int v0, lat;
    v0 = valid1_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drdy1 = 1'b1;
      @(negedge clk);
      drdy1 = 1'b0;
      wait_valid(1'b1, lat);
      checks++;
      if (lat + 1 != 163) begin
        errors++; $display("FAIL fast_latency[%0d]: got %0d required 163", i, lat + 1);
      end
      // Period shortened from 40000 cycles to about 400 to keep the run short.
      repeat (236) @(negedge clk);
    end
    checks++;
    if ((valid1_cnt - v0 != 10) || (ovr1 !== 1'b0)) begin
      errors++; $display("FAIL fast_summary: got valid=%0d ovr=%b required 10 0",
                         valid1_cnt - v0, ovr1);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_overrun();
    test_enable();
    test_mid_reset();
    test_fast();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
